// File: rtl/image_out_sram.sv
// Streams one stored RGB565 frame out of external SRAM as valid/ready pixels, one read in flight at a time.
// Optional IMG_OUT_LOOP_EN: wrap to pixel 0 after the last pixel and pulse done once per frame.
module image_out_sram #(
    parameter logic [18:0] BASE_ADDR = 19'h00000,
    parameter int          PIX_COUNT = 76800,
    parameter int          RD_LAT    = 2
) (
    input  logic        wclk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        sram_sel,
    output logic        sram_wr,
    output logic        sram_rd,
    output logic [18:0] sram_addr,
    input  logic [15:0] sram_rdata,
    output logic [15:0] pix_data,
    output logic [16:0] pix_addr,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_OUT, S_DONE} state_t;

    localparam logic [16:0] LAST_PIX  = 17'(PIX_COUNT - 1);
    localparam logic [2:0]  WAIT_INIT = 3'(RD_LAT - 1);

    state_t      state;
    logic [16:0] count;
    logic [2:0]  wait_cnt;
    logic [16:0] count_inc;

    assign count_inc = count + 17'd1;
    assign sram_wr   = 1'b0;
    // Chip select and read strobe always move together.
    assign sram_sel  = sram_rd;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            wait_cnt  <= '0;
            sram_rd   <= 1'b0;
            sram_addr <= '0;
            pix_data  <= '0;
            pix_addr  <= '0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
        end else if (!enable && state != S_IDLE && state != S_DONE) begin
            // Abort: any read in flight is dropped and its pixel never delivered.
            state     <= S_IDLE;
            count     <= '0;
            wait_cnt  <= '0;
            sram_rd   <= 1'b0;
            sram_addr <= '0;
            pix_data  <= '0;
            pix_addr  <= '0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        count     <= '0;
                        sram_rd   <= 1'b1;
                        sram_addr <= BASE_ADDR;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    wait_cnt <= WAIT_INIT;
                    done     <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        pix_data  <= sram_rdata;
                        pix_addr  <= count;
                        pix_valid <= 1'b1;
                        sram_rd   <= 1'b0;
                        sram_addr <= '0;
                        state     <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (count == LAST_PIX) begin
`ifdef IMG_OUT_LOOP_EN
                            count     <= '0;
                            sram_rd   <= 1'b1;
                            sram_addr <= BASE_ADDR;
                            done      <= 1'b1;
                            state     <= S_ADDR;
`else
                            done      <= 1'b1;
                            state     <= S_DONE;
`endif
                        end else begin
                            count     <= count_inc;
                            sram_rd   <= 1'b1;
                            sram_addr <= BASE_ADDR + {2'b00, count_inc};
                            state     <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    // Stay parked until enable drops, so a frame never re-runs back to back.
                    if (!enable) begin
                        done     <= 1'b0;
                        pix_data <= '0;
                        pix_addr <= '0;
                        count    <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
